// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one main-memory block port between an I-cache and a D-cache
module mem_port_arbiter #(
    parameter int ADDR_W  = 28,
    parameter int BLOCK_W = 128
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               I_READ,
    input  logic [ADDR_W-1:0]  I_ADDRESS,
    output logic [BLOCK_W-1:0] I_READDATA,
    output logic               I_BUSYWAIT,
    input  logic               D_READ,
    input  logic               D_WRITE,
    input  logic [ADDR_W-1:0]  D_ADDRESS,
    input  logic [BLOCK_W-1:0] D_WRITEDATA,
    output logic [BLOCK_W-1:0] D_READDATA,
    output logic               D_BUSYWAIT,
    output logic               M_READ,
    output logic               M_WRITE,
    output logic [ADDR_W-1:0]  M_ADDRESS,
    output logic [BLOCK_W-1:0] M_WRITEDATA,
    input  logic [BLOCK_W-1:0] M_READDATA,
    input  logic               M_BUSYWAIT
);
    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, RELEASE} state_t;
    state_t state, state_nxt;
    logic owner, last_grant, busy_seen;
    logic i_req, d_req, pick_d, granting, in_grant, done;
    assign i_req    = I_READ;
    assign d_req    = D_READ | D_WRITE;
    assign pick_d   = d_req & (~i_req | ~last_grant);
    assign granting = (state == IDLE) & (i_req | d_req);
    assign in_grant = (state == GRANT_I) | (state == GRANT_D);
    assign done     = in_grant & ~M_BUSYWAIT & busy_seen;
    assign I_BUSYWAIT = i_req & ~((state == RELEASE) & ~owner);
    assign D_BUSYWAIT = d_req & ~((state == RELEASE) & owner);
    // state register
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= IDLE;
        else       state <= state_nxt;
    end
    // next-state: grant from IDLE, release once memory has been busy and then idle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = granting ? (pick_d ? GRANT_D : GRANT_I) : IDLE;
            GRANT_I,
            GRANT_D: state_nxt = done ? RELEASE : state;
            default: state_nxt = IDLE;
        endcase
    end
    // latched command/address/data, ownership bookkeeping and read-data capture
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            owner       <= 1'b0;
            last_grant  <= 1'b0;
            busy_seen   <= 1'b0;
            M_READ      <= 1'b0;
            M_WRITE     <= 1'b0;
            M_ADDRESS   <= '0;
            M_WRITEDATA <= '0;
            I_READDATA  <= '0;
            D_READDATA  <= '0;
        end else begin
            if (granting) begin
                owner       <= pick_d;
                busy_seen   <= 1'b0;
                M_READ      <= pick_d ? (D_READ & ~D_WRITE) : 1'b1;
                M_WRITE     <= pick_d & D_WRITE;
                M_ADDRESS   <= pick_d ? D_ADDRESS : I_ADDRESS;
                M_WRITEDATA <= pick_d ? D_WRITEDATA : '0;
            end
            if (in_grant && M_BUSYWAIT) busy_seen <= 1'b1;
            if (done) begin
                M_READ  <= 1'b0;
                M_WRITE <= 1'b0;
                if (M_READ && !owner) I_READDATA <= M_READDATA;
                if (M_READ && owner)  D_READDATA <= M_READDATA;
            end
            if (state == RELEASE) last_grant <= owner;
        end
    end
endmodule
